// File: rtl/debouncer_pkg.sv
// Shared definitions for the multi-channel debouncer: mode selectors and the
// per-mode channel state encodings.
package debouncer_pkg;

  localparam int MODE_DELAYED = 0;
  localparam int MODE_EARLY   = 1;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } delayed_state_e;

  typedef enum logic {
    STABLE,
    LOCKOUT
  } early_state_e;

endpackage

// File: rtl/debouncer_channel.sv
// One debounce channel: input synchroniser, mode-specific FSM with a
// saturating stability/lockout counter, and registered edge pulses.
module debouncer_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 20_000_000,
  parameter int          SYNC_STAGES  = 2,
  parameter int          MODE         = MODE_DELAYED
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  output logic debounced,
  output logic rise,
  output logic fall
);

  localparam int            CW   = $clog2(DELAY_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DELAY_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (MODE == MODE_EARLY) begin : g_early
    // Output follows the first edge at once; the lockout then masks bounce.
    early_state_e state;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= STABLE;
        count     <= '0;
        debounced <= 1'b0;
        rise      <= 1'b0;
        fall      <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        case (state)
          STABLE: begin
            if (sync != debounced) begin
              debounced <= sync;
              rise      <= sync;
              fall      <= ~sync;
              count     <= '0;
              state     <= LOCKOUT;
            end
          end
          LOCKOUT: begin
            if (count == LAST) begin
              count <= '0;
              state <= STABLE;
            end else begin
              count <= count + CW'(1);
            end
          end
          default: begin
            count <= '0;
            state <= STABLE;
          end
        endcase
      end
    end
  end else begin : g_delayed
    // Output changes only after the new level has held for the full delay.
    delayed_state_e state;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= STABLE_LO;
        count     <= '0;
        debounced <= 1'b0;
        rise      <= 1'b0;
        fall      <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        case (state)
          STABLE_LO: begin
            if (sync) begin
              count <= '0;
              state <= WAIT_HI;
            end
          end
          WAIT_HI: begin
            if (!sync) begin
              count <= '0;
              state <= STABLE_LO;
            end else if (count == LAST) begin
              count     <= '0;
              debounced <= 1'b1;
              rise      <= 1'b1;
              state     <= STABLE_HI;
            end else begin
              count <= count + CW'(1);
            end
          end
          STABLE_HI: begin
            if (!sync) begin
              count <= '0;
              state <= WAIT_LO;
            end
          end
          WAIT_LO: begin
            if (sync) begin
              count <= '0;
              state <= STABLE_HI;
            end else if (count == LAST) begin
              count     <= '0;
              debounced <= 1'b0;
              fall      <= 1'b1;
              state     <= STABLE_LO;
            end else begin
              count <= count + CW'(1);
            end
          end
          default: begin
            count <= '0;
            state <= STABLE_LO;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/debouncer_multi.sv
// Bank of N_CH independent debounce channels sharing one clock and reset.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int          N_CH         = 4,
  parameter int unsigned DELAY_CYCLES = 20_000_000,
  parameter int          SYNC_STAGES  = 2,
  parameter int          MODE         = MODE_DELAYED
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debouncer_channel #(
      .DELAY_CYCLES (DELAY_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .MODE         (MODE)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .noisy     (noisy[i]),
      .debounced (debounced[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

endmodule
